// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants for the forwarding scoreboard: parameter defaults and the
// forwarding-select encoding used across the pipeline.
package fwd_scoreboard_pkg;

   localparam int REG_W_DEF = 4;
   localparam int NSRC_DEF  = 2;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 16;
   localparam int DEPTH_MAX = 7;

   // Select value meaning "take the operand from the register file".
   localparam int SEL_RF = 0;

   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_match_sel.sv
// Priority match of one EX source operand against the tracked post-EX writes;
// the youngest (lowest-numbered) matching entry wins.
module fwd_match_sel
   import fwd_scoreboard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int SEL_W = sel_width(DEPTH_DEF)
) (
   input  logic                   en,
   input  logic [REG_W-1:0]       src,
   input  logic [DEPTH-1:0]       ent_valid,
   input  logic [DEPTH-1:0]       ent_wb_en,
   input  logic [DEPTH*REG_W-1:0] ent_dest,
   output logic [SEL_W-1:0]       sel
);

   // Scan oldest to youngest so the youngest hit is the last assignment.
   always_comb begin
      sel = SEL_W'(SEL_RF);
      for (int k = DEPTH; k >= 1; k--) begin
         if (en && ent_valid[k-1] && ent_wb_en[k-1] &&
             (ent_dest[(k-1)*REG_W +: REG_W] == src)) begin
            sel = SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard scoreboard: tracks in-flight register writes after EX,
// selects forwarding sources for EX operands and raises stalls for ID.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int NSRC  = NSRC_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fwd_en,
   input  logic                          advance,
   input  logic                          ex_valid,
   input  logic                          ex_wb_en,
   input  logic                          ex_mem_r_en,
   input  logic [REG_W-1:0]              ex_dest,
   input  logic [NSRC*REG_W-1:0]         ex_src_flat,
   input  logic [NSRC*REG_W-1:0]         id_src_flat,
   input  logic [NSRC-1:0]               ex_src_used,
   input  logic [NSRC-1:0]               id_src_used,
   input  logic                          cnt_clr,
   output logic [NSRC*sel_width(DEPTH)-1:0] sel_flat,
   output logic                          hazard,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int SEL_W = sel_width(DEPTH);

   logic [DEPTH-1:0]       ent_valid;
   logic [DEPTH-1:0]       ent_wb_en;
   logic [DEPTH-1:0]       ent_mem_r_en;
   logic [DEPTH*REG_W-1:0] ent_dest;

   // Entry valid bits are control and are cleared by reset; a reset discards
   // every tracked write.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid <= '0;
      end else if (advance) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            ent_valid[k] <= ent_valid[k-1];
         end
         ent_valid[0] <= ex_valid;
      end
   end

   // Payload is qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            ent_wb_en[k]                  <= ent_wb_en[k-1];
            ent_mem_r_en[k]               <= ent_mem_r_en[k-1];
            ent_dest[k*REG_W +: REG_W]    <= ent_dest[(k-1)*REG_W +: REG_W];
         end
         ent_wb_en[0]          <= ex_wb_en;
         ent_mem_r_en[0]       <= ex_mem_r_en;
         ent_dest[0 +: REG_W]  <= ex_dest;
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_match
      fwd_match_sel #(
         .REG_W (REG_W),
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_match (
         .en        (fwd_en & ex_src_used[i]),
         .src       (ex_src_flat[i*REG_W +: REG_W]),
         .ent_valid (ent_valid),
         .ent_wb_en (ent_wb_en),
         .ent_dest  (ent_dest),
         .sel       (sel_flat[i*SEL_W +: SEL_W])
      );
   end

   // With forwarding only a load in EX stalls; without it any pending write
   // stalls except the last entry, which the register file already sees.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (id_src_used[i]) begin
            if (fwd_en) begin
               if (ex_valid && ex_wb_en && ex_mem_r_en &&
                   (ex_dest == id_src_flat[i*REG_W +: REG_W])) begin
                  hazard = 1'b1;
               end
            end else begin
               if (ex_valid && ex_wb_en &&
                   (ex_dest == id_src_flat[i*REG_W +: REG_W])) begin
                  hazard = 1'b1;
               end
               for (int k = 0; k < DEPTH - 1; k++) begin
                  if (ent_valid[k] && ent_wb_en[k] &&
                      (ent_dest[k*REG_W +: REG_W] == id_src_flat[i*REG_W +: REG_W])) begin
                     hazard = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (hazard && advance && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_fwd_scoreboard;

   localparam int REG_W = 4;
   localparam int NSRC  = 2;
   localparam int DEPTH = 2;
   localparam int CNT_W = 4;
   localparam int SEL_W = $clog2(DEPTH + 1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst, fwd_en, advance, cnt_clr;
   logic                  ex_valid, ex_wb_en, ex_mem_r_en;
   logic [REG_W-1:0]      ex_dest;
   logic [NSRC*REG_W-1:0] ex_src_flat, id_src_flat;
   logic [NSRC-1:0]       ex_src_used, id_src_used;
   logic [NSRC*SEL_W-1:0] sel_flat;
   logic                  hazard;
   logic [CNT_W-1:0]      stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   fwd_scoreboard #(
      .REG_W (REG_W),
      .NSRC  (NSRC),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fwd_en      (fwd_en),
      .advance     (advance),
      .ex_valid    (ex_valid),
      .ex_wb_en    (ex_wb_en),
      .ex_mem_r_en (ex_mem_r_en),
      .ex_dest     (ex_dest),
      .ex_src_flat (ex_src_flat),
      .id_src_flat (id_src_flat),
      .ex_src_used (ex_src_used),
      .id_src_used (id_src_used),
      .cnt_clr     (cnt_clr),
      .sel_flat    (sel_flat),
      .hazard      (hazard),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: history of instructions that left EX, youngest first.
   typedef struct {
      bit             v;
      bit             wb;
      bit             mr;
      logic [REG_W-1:0] d;
   } wr_t;

   wr_t hist[$];
   int  m_cnt    = 0;
   bit  checking = 0;

   function automatic int m_sel(input int i);
      logic [REG_W-1:0] s;
      s = ex_src_flat[i*REG_W +: REG_W];
      if (!fwd_en || !ex_src_used[i]) return 0;
      for (int k = 0; k < hist.size(); k++)
         if (hist[k].v && hist[k].wb && hist[k].d == s) return k + 1;
      return 0;
   endfunction

   function automatic bit m_hazard();
      logic [REG_W-1:0] s;
      bit ex_wr;
      ex_wr = ex_valid && ex_wb_en;
      for (int i = 0; i < NSRC; i++) begin
         s = id_src_flat[i*REG_W +: REG_W];
         if (!id_src_used[i]) continue;
         if (fwd_en) begin
            if (ex_wr && ex_mem_r_en && ex_dest == s) return 1;
         end else begin
            if (ex_wr && ex_dest == s) return 1;
            for (int k = 0; k < hist.size() && k < DEPTH - 1; k++)
               if (hist[k].v && hist[k].wb && hist[k].d == s) return 1;
         end
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      bit h;
      wr_t e;
      h = m_hazard();
      if (rst) begin
         hist.delete();
         m_cnt    = 0;
         checking = 1;
      end else begin
         if (cnt_clr)               m_cnt = 0;
         else if (h && advance)     m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         if (advance) begin
            e.v = ex_valid; e.wb = ex_wb_en; e.mr = ex_mem_r_en; e.d = ex_dest;
            hist.push_front(e);
            while (hist.size() > DEPTH) void'(hist.pop_back());
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dut_sel(input int i);
      return int'(sel_flat[i*SEL_W +: SEL_W]);
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < NSRC; i++) chk($sformatf("model_sel%0d", i), dut_sel(i), m_sel(i));
         chk("model_hazard", int'(hazard), int'(m_hazard()));
         chk("model_stall_cnt", int'(stall_cnt), m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input bit v, input bit wb, input bit mr, input int d);
      ex_valid = v; ex_wb_en = wb; ex_mem_r_en = mr; ex_dest = REG_W'(d);
   endtask

   task automatic set_exsrc(input int i, input int r, input bit u);
      ex_src_flat[i*REG_W +: REG_W] = REG_W'(r);
      ex_src_used[i] = u;
   endtask

   task automatic set_idsrc(input int i, input int r, input bit u);
      id_src_flat[i*REG_W +: REG_W] = REG_W'(r);
      id_src_used[i] = u;
   endtask

   initial begin
      rst = 1; fwd_en = 1; advance = 0; cnt_clr = 0;
      set_ex(0, 0, 0, 0);
      ex_src_flat = '0; id_src_flat = '0; ex_src_used = '0; id_src_used = '0;
      tick();
      rst = 0;
      @(negedge clk);
      chk("reset_sel_flat", int'(sel_flat), 0);
      chk("reset_hazard", int'(hazard), 0);
      chk("reset_stall_cnt", int'(stall_cnt), 0);

      // Write to r3 travels MEM -> WB -> gone.
      set_ex(1, 1, 0, 3); advance = 1; tick();
      set_ex(0, 0, 0, 0); advance = 0; set_exsrc(0, 3, 1);
      @(negedge clk); chk("r3_sel0_mem", dut_sel(0), 1);
      advance = 1; tick(); advance = 0;
      @(negedge clk); chk("r3_sel0_wb", dut_sel(0), 2);
      advance = 1; tick(); advance = 0;
      @(negedge clk); chk("r3_sel0_gone", dut_sel(0), 0);

      // Two writes to r5: the younger one wins.
      set_ex(1, 1, 0, 5); advance = 1; tick(); tick();
      set_ex(0, 0, 0, 0); advance = 0; set_exsrc(1, 5, 1);
      @(negedge clk); chk("r5_youngest_sel1", dut_sel(1), 1);

      // Load-use in forwarding mode.
      set_ex(1, 1, 1, 7); set_idsrc(0, 7, 1);
      @(negedge clk); chk("load_use_hazard", int'(hazard), 1);
      set_idsrc(0, 7, 0);
      @(negedge clk); chk("load_use_unused", int'(hazard), 0);

      // Stall-only mode.
      fwd_en = 0;
      set_ex(1, 1, 0, 4); set_idsrc(0, 4, 1);
      @(negedge clk); chk("stall_ex_match", int'(hazard), 1);
      set_idsrc(0, 4, 0);
      set_ex(1, 1, 0, 2); advance = 1; tick();
      set_ex(0, 0, 0, 0); advance = 0; set_idsrc(1, 2, 1);
      @(negedge clk);
      chk("stall_entry1_hazard", int'(hazard), 1);
      chk("stall_sel_flat_zero", int'(sel_flat), 0);
      advance = 1; tick(); advance = 0;
      @(negedge clk); chk("stall_last_entry_free", int'(hazard), 0);
      set_idsrc(1, 2, 0);

      // Freeze holds the entries in place.
      fwd_en = 1;
      set_ex(1, 1, 0, 9); advance = 1; tick();
      set_ex(0, 0, 0, 0); advance = 0; set_exsrc(0, 9, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); chk($sformatf("freeze_sel0_c%0d", c), dut_sel(0), 1);
         tick();
      end
      advance = 1; tick(); advance = 0;
      @(negedge clk); chk("freeze_then_shift", dut_sel(0), 2);

      // Saturating stall counter, clear, and reset mid-flight.
      cnt_clr = 1; tick(); cnt_clr = 0;
      @(negedge clk); chk("cnt_cleared", int'(stall_cnt), 0);
      set_ex(1, 1, 1, 7); set_idsrc(0, 7, 1); advance = 1;
      for (int c = 0; c < 20; c++) tick();
      advance = 0;
      @(negedge clk); chk("cnt_saturated", int'(stall_cnt), 15);
      cnt_clr = 1; tick(); cnt_clr = 0;
      @(negedge clk); chk("cnt_clr_after_sat", int'(stall_cnt), 0);
      set_exsrc(0, 7, 1);
      @(negedge clk); chk("pre_rst_sel0", dut_sel(0), 1);
      rst = 1; advance = 1; tick(); rst = 0; advance = 0;
      @(negedge clk);
      chk("post_rst_sel_flat", int'(sel_flat), 0);
      chk("post_rst_hazard_ex_only", int'(hazard), 1);
      chk("post_rst_cnt", int'(stall_cnt), 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
